// File: rtl/avalon_host_master.sv
// avalon_host_master: Avalon-MM initiator serving one host command at a time.
// Each command produces exactly one response. Supported commands are a single
// write, a single read, or a poll. A poll repeats reads until a masked compare
// matches or MAX_POLLS reads have been made.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   cmd_*             host command channel (valid/ready); op 00 wr, 01 rd, 10 poll, 11 illegal
//   rsp_*             one-cycle response pulse with held data/flags
//   master_*          Avalon-MM initiator port (no waitrequest, fixed read latency)
module avalon_host_master #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned MAX_POLLS    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic [DATA_W-1:0] master_readdata
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PCNT_W = 8;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    GAP,
    RESP
  } state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   mask_q;
  logic [DATA_W-1:0]   cmp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PCNT_W-1:0]   poll_cnt_q;

  // Masked compare against the data returned on this cycle.
  logic hit_c;
  assign hit_c = ((master_readdata & mask_q) == cmp_q);

  // Last poll read: the incremented count reaches MAX_POLLS.
  logic last_poll_c;
  assign last_poll_c = (({1'b0, poll_cnt_q} + (PCNT_W+1)'(1)) == (PCNT_W+1)'(MAX_POLLS));

  // Command FSM. Strobes and responses are registered. They are therefore set
  // on the edge that enters the cycle in which they must be visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      op_q             <= OP_WR;
      mask_q           <= '0;
      cmp_q            <= '0;
      cnt_q            <= '0;
      poll_cnt_q       <= '0;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_timeout      <= 1'b0;
      rsp_error        <= 1'b0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
    end else begin
      master_read  <= 1'b0;
      master_write <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            mask_q     <= cmd_mask;
            cmp_q      <= cmd_wdata & cmd_mask;
            poll_cnt_q <= '0;
            cmd_ready  <= 1'b0;
            if (cmd_op == OP_ILL) begin
              // Illegal ops are rejected in cycle 1 without touching the bus.
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b0;
              rsp_error   <= 1'b1;
              state_q     <= RESP;
            end else begin
              master_address <= cmd_address;
              if (cmd_op == OP_WR) begin
                master_write     <= 1'b1;
                master_writedata <= cmd_wdata;
              end else begin
                master_read <= 1'b1;
              end
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (op_q == OP_WR) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q   <= CNT_W'(READ_LATENCY - 1);
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // Data is valid now. The match check is folded into this last wait
            // cycle, so the response lands in cycle 2+READ_LATENCY.
            poll_cnt_q <= poll_cnt_q + PCNT_W'(1);
            if ((op_q != OP_POLL) || hit_c || last_poll_c) begin
              rsp_valid   <= 1'b1;
              rsp_rdata   <= master_readdata;
              rsp_timeout <= (op_q == OP_POLL) && !hit_c;
              rsp_error   <= 1'b0;
              state_q     <= RESP;
            end else if (POLL_GAP == 0) begin
              master_read <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              cnt_q   <= CNT_W'(POLL_GAP - 1);
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            master_read <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_host_master.sv
// Directed bench for avalon_host_master with a small register-slave model.
module tb_avalon_host_master;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              rsp_error;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic [DATA_W-1:0] master_readdata;

  avalon_host_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .POLL_GAP(4), .MAX_POLLS(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .rsp_error(rsp_error), .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_readdata(master_readdata)
  );

  always #5 clk = ~clk;

  // Slave: 8 word registers; address 0x04 returns a counter 0x0E,0x0F,...
  logic [31:0] mem [8];
  logic [31:0] poll_off;
  always @(posedge clk) begin
    if (reset) poll_off <= 32'd0;
    if (master_write) mem[master_address[4:2]] <= master_writedata;
    if (master_read) begin
      if (master_address == 5'h04) begin
        master_readdata <= 32'h0E + poll_off;
        poll_off        <= poll_off + 32'd1;
      end else begin
        master_readdata <= mem[master_address[4:2]];
      end
    end
  end

  // Bus / response monitor.
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, both_cnt = 0;
  int last_rd_cyc = 0, prev_rd_cyc = 0, last_wr_cyc = 0;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (master_read) begin
      rd_cnt++;
      prev_rd_cyc = last_rd_cyc;
      last_rd_cyc = cyc;
    end
    if (master_write) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = master_address;
      last_wr_data = master_writedata;
    end
    if (master_read && master_write) both_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int hs_cyc;
  int r_lat;
  logic [31:0] r_rdata;
  logic r_to, r_err;

  // Wait for ready, handshake, and return in cycle 1 of the command.
  task automatic start_cmd(input logic [1:0] op, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] m);
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_address = a; cmd_wdata = wd; cmd_mask = m;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    hs_cyc = cyc;
  endtask

  // r_lat is the cycle (handshake = 0) in which rsp_valid is seen; 0 on timeout.
  task automatic wait_rsp();
    r_lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        r_lat = i;
        break;
      end
    end
    r_rdata = rsp_rdata; r_to = rsp_timeout; r_err = rsp_error;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a,
                        input logic [31:0] wd, input logic [31:0] m);
    start_cmd(op, a, wd, m);
    wait_rsp();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {26'd0, master_read, master_write, rsp_valid, rsp_timeout,
                          rsp_error, cmd_ready}, 32'h1);
    check({tag, "_addr"}, {27'd0, master_address}, 32'h0);
    check({tag, "_wdata"}, master_writedata, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  int rd0, wr0, rsp0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_address = '0;
    cmd_wdata = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: write 0x3 to 0x00
    wr0 = wr_cnt;
    do_cmd(2'b00, 5'h00, 32'h3, 32'h0);
    check("wr_lat", r_lat, 32'd2);
    check("wr_strobes", wr_cnt - wr0, 32'd1);
    check("wr_strobe_cyc", last_wr_cyc - hs_cyc + 1, 32'd1);
    check("wr_addr", {27'd0, last_wr_addr}, 32'h0);
    check("wr_data", last_wr_data, 32'h3);
    check("wr_rsp", {r_rdata[30:0], r_to, r_err} , 32'h0);

    do_cmd(2'b00, 5'h0C, 32'd20, 32'h0);
    do_cmd(2'b00, 5'h08, 32'h0, 32'h0);

    // 2: read 0x0C -> 20
    rd0 = rd_cnt;
    do_cmd(2'b01, 5'h0C, 32'h0, 32'h0);
    check("rd_lat", r_lat, 32'd3);
    check("rd_data", r_rdata, 32'd20);
    check("rd_strobes", rd_cnt - rd0, 32'd1);
    check("rd_strobe_cyc", last_rd_cyc - hs_cyc + 1, 32'd1);
    @(negedge clk);
    check("rsp_hold", {rsp_valid, rsp_rdata[30:0]}, 32'd20);

    // 3: poll 0x04 for 0x10 under mask 0xFF; data 0x0E,0x0F,0x10
    rd0 = rd_cnt;
    do_cmd(2'b10, 5'h04, 32'h10, 32'hFF);
    check("poll_reads", rd_cnt - rd0, 32'd3);
    check("poll_spacing", last_rd_cyc - prev_rd_cyc, 32'd6);
    check("poll_data", r_rdata, 32'h10);
    check("poll_to", {31'd0, r_to}, 32'd0);
    check("poll_lat", r_lat, 32'd15);

    // 4: poll never matching -> MAX_POLLS=3 reads, timeout
    rd0 = rd_cnt;
    do_cmd(2'b10, 5'h08, 32'h55, 32'hFF);
    check("to_reads", rd_cnt - rd0, 32'd3);
    check("to_flag", {30'd0, r_to, r_err}, 32'h2);
    check("to_data", r_rdata, 32'h0);

    // mask 0 matches on the first read
    rd0 = rd_cnt;
    do_cmd(2'b10, 5'h0C, 32'hFFFF, 32'h0);
    check("mask0_reads", rd_cnt - rd0, 32'd1);
    check("mask0_rsp", {r_rdata[29:0], r_to, r_err}, {30'd20, 2'b00});

    // 5: illegal op; previous timeout flag must clear
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_cmd(2'b11, 5'h00, 32'h0, 32'h0);
    check("ill_lat", r_lat, 32'd1);
    check("ill_flags", {30'd0, r_to, r_err}, 32'h1);
    check("ill_nostrobe", (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);
    @(negedge clk);
    check("ill_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(2'b01, 5'h00, 32'h0, 32'h0);
    check("after_ill", {r_rdata[29:0], r_to, r_err}, {30'd3, 2'b00});
    check("after_ill_lat", r_lat, 32'd3);

    // 6a: reset during WAIT_RD
    start_cmd(2'b01, 5'h0C, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rsp0 = rsp_cnt;
    reset = 1'b1;
    #1 check_reset_outputs("rst_wait");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_wait_norsp", rsp_cnt - rsp0, 32'd0);

    // 6b: reset during GAP of a poll
    start_cmd(2'b10, 5'h08, 32'h55, 32'hFF);
    repeat (4) @(negedge clk);
    rsp0 = rsp_cnt; rd0 = rd_cnt;
    reset = 1'b1;
    #1 check_reset_outputs("rst_gap");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_gap_norsp", rsp_cnt - rsp0, 32'd0);
    check("rst_gap_noread", rd_cnt - rd0, 32'd0);

    wr0 = wr_cnt;
    do_cmd(2'b00, 5'h10, 32'hA5, 32'h0);
    check("post_rst_wr_lat", r_lat, 32'd2);
    check("post_rst_wr", wr_cnt - wr0, 32'd1);
    do_cmd(2'b01, 5'h10, 32'h0, 32'h0);
    check("post_rst_rd", r_rdata, 32'hA5);

    check("rd_wr_exclusive", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
